// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer scan reader.
// Optional build macro FB_SCAN_DOUBLE_EN (2x2 pixel replication) is consumed in fb_scan_reader.sv.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fb_state_e;

  // Ceiling log2, never below 1 so it can size a pointer even for tiny depths.
  function automatic int fb_log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int FB_H_ACTIVE   = 160;
  localparam int FB_V_ACTIVE   = 120;
  localparam int FB_PIXELS     = FB_H_ACTIVE * FB_V_ACTIVE;
  localparam int FB_LAST       = FB_PIXELS - 1;
  localparam int FB_FIFO_DEPTH = 4;
  localparam int FIFO_AW       = fb_log2(FB_FIFO_DEPTH);

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Synchronous show-ahead FIFO: rdata_o always shows the head entry.
// Storage is cleared on reset so the head reads as zero out of reset.
module fb_prefetch_fifo
  import fb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = fb_log2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic [AW:0]   count_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  // Storage, pointers and occupancy; the producer guarantees no push when full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fb_scan_reader.sv
// Framebuffer read-side scanner: walks the RAM linearly on start, hides the
// 1-cycle RAM latency behind a prefetch FIFO and emits a valid/ready pixel
// stream with sof/eol/eof markers.
// Build macro FB_SCAN_DOUBLE_EN: 2x2 replication (each pixel shown twice,
// each RAM line fetched twice, markers on the doubled extents).
//
// state | meaning
// IDLE  | waiting for start, no reads issued
// FETCH | issuing reads while FIFO + in-flight has room
// DRAIN | all reads issued, emptying FIFO until last pixel accepted
module fb_scan_reader
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int H_ACTIVE   = FB_H_ACTIVE,
  parameter int V_ACTIVE   = FB_V_ACTIVE,
  parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic                  pix_sof_o,
  output logic                  pix_eol_o,
  output logic                  pix_eof_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int FAW = fb_log2(FIFO_DEPTH);
  localparam int CW  = FAW + 2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);
`ifdef FB_SCAN_DOUBLE_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif
  localparam int OUT_H = REP * H_ACTIVE;
  localparam int OUT_V = REP * V_ACTIVE;
  localparam int XW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int YW    = (OUT_V > 1) ? $clog2(OUT_V) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(OUT_H - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_V - 1);

  fb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q;
  logic [XW-1:0]         ox_q, ox_d;
  logic [YW-1:0]         oy_q, oy_d;
  logic                  issue;
  logic                  hs;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [FAW:0]          fifo_count;
  logic                  fifo_empty;
  logic                  done;
`ifdef FB_SCAN_DOUBLE_EN
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic                  pass_q, pass_d;
  logic                  rep_q, rep_d;
  logic [ADDR_WIDTH-1:0] line_end;
  assign line_end = line_q + ADDR_WIDTH'(H_ACTIVE - 1);
`endif

  // Reads are issued only when the FIFO has room for everything already in flight.
  assign issue = (state_q == FETCH) &&
                 ((CW'(fifo_count) + CW'(inflight_q)) < CW'(FIFO_DEPTH));
  assign hs    = pix_valid_o && pix_ready_i;
`ifdef FB_SCAN_DOUBLE_EN
  assign fifo_pop = hs && rep_q;
`else
  assign fifo_pop = hs;
`endif

  fb_prefetch_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FAW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .wdata_i (ram_rdata_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Next-state and fetch-address logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done    = 1'b0;
`ifdef FB_SCAN_DOUBLE_EN
    line_d  = line_q;
    pass_d  = pass_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          addr_d  = '0;
`ifdef FB_SCAN_DOUBLE_EN
          line_d  = '0;
          pass_d  = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (issue) begin
`ifdef FB_SCAN_DOUBLE_EN
          // Each line is read twice: rewind to the line start after the first pass.
          if (addr_q == line_end) begin
            if (!pass_q) begin
              addr_d = line_q;
              pass_d = 1'b1;
            end else if (addr_q == ADDR_LAST) begin
              state_d = DRAIN;
            end else begin
              addr_d = addr_q + 1'b1;
              line_d = addr_q + 1'b1;
              pass_d = 1'b0;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
`else
          if (addr_q == ADDR_LAST) state_d = DRAIN;
          else addr_d = addr_q + 1'b1;
`endif
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output position counters (and replication phase) advance on every handshake.
  always_comb begin
    ox_d = ox_q;
    oy_d = oy_q;
`ifdef FB_SCAN_DOUBLE_EN
    rep_d = rep_q;
`endif
    if (state_q == IDLE && start_i) begin
      ox_d = '0;
      oy_d = '0;
`ifdef FB_SCAN_DOUBLE_EN
      rep_d = 1'b0;
`endif
    end else if (hs) begin
`ifdef FB_SCAN_DOUBLE_EN
      rep_d = !rep_q;
`endif
      if (ox_q == X_LAST) begin
        ox_d = '0;
        oy_d = (oy_q == Y_LAST) ? '0 : oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end
  end

  // State, address and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
`ifdef FB_SCAN_DOUBLE_EN
      line_q     <= '0;
      pass_q     <= 1'b0;
      rep_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= issue;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
`ifdef FB_SCAN_DOUBLE_EN
      line_q     <= line_d;
      pass_q     <= pass_d;
      rep_q      <= rep_d;
`endif
    end
  end

  assign ram_addr_o   = addr_q;
  assign pix_valid_o  = !fifo_empty;
  assign pix_data_o   = fifo_head;
  assign pix_sof_o    = pix_valid_o && (ox_q == '0) && (oy_q == '0);
  assign pix_eol_o    = pix_valid_o && (ox_q == X_LAST);
  assign pix_eof_o    = pix_eol_o && (oy_q == Y_LAST);
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Randomized bench for fb_scan_reader with a frame-level reference model.
module tb_fb_scan_reader;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int DEPTH = 4;
  localparam int NPIX  = H * V;
`ifdef FB_SCAN_DOUBLE_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ram_addr;
  logic [7:0]  ram_rdata = '0;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_sof, pix_eol, pix_eof;
  logic        busy, frame_done;

  logic [7:0]  mem [NPIX];
  logic [11:0] exp_q [$];
  logic [11:0] e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          popped   = 0;
  int          done_cnt = 0;
  bit          oob      = 0;
  bit          prev_stall = 0;
  bit          prev_hs    = 0;
  logic [7:0]  prev_data  = '0;

  always #5 clk = ~clk;

  fb_scan_reader #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (16),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .ram_addr_o   (ram_addr),
    .ram_rdata_i  (ram_rdata),
    .pix_valid_o  (pix_valid),
    .pix_ready_i  (pix_ready),
    .pix_data_o   (pix_data),
    .pix_sof_o    (pix_sof),
    .pix_eol_o    (pix_eol),
    .pix_eof_o    (pix_eof),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  // Synchronous-read RAM model.
  always @(posedge clk) begin
    if (int'(ram_addr) < NPIX) ram_rdata <= mem[int'(ram_addr)];
    else ram_rdata <= 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected stream: raster scan of the (possibly replicated) image.
  task automatic build_expected();
    exp_q.delete();
    for (int y = 0; y < V * REP; y++) begin
      for (int x = 0; x < H * REP; x++) begin
        logic sof, eol, eof;
        sof = (x == 0) && (y == 0);
        eol = (x == H * REP - 1);
        eof = eol && (y == V * REP - 1);
        exp_q.push_back({1'b0, mem[(y / REP) * H + (x / REP)], sof, eol, eof});
      end
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_hs    = 0;
    end else begin
      if (prev_stall) check("stall_hold", {pix_valid, pix_data}, {1'b1, prev_data});
      if (frame_done) begin
        done_cnt++;
        check("done_lat", {prev_hs, exp_q.size() == 0}, 2'b11);
      end
      if (pix_valid && pix_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        check("pix", {pix_data, pix_sof, pix_eol, pix_eof}, e);
        popped++;
      end
      if (int'(ram_addr) > NPIX - 1) oob = 1;
`ifndef FB_SCAN_DOUBLE_EN
      if (busy && int'(ram_addr) > popped + DEPTH) oob = 1;
`endif
      prev_hs    = pix_valid && pix_ready;
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
    end
  end

  // mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random, 3 held low 20 cycles
  task automatic run_frame(input int mode, input bit mid_start, input int abort_at);
    bit mid_done;
    int extra;
    bit finished;
    mid_done = 0;
    extra    = 0;
    finished = 0;
    build_expected();
    popped   = 0;
    done_cnt = 0;
    oob      = 0;
    @(posedge clk);
    #1 start = 1'b1;
    pix_ready = (mode == 0) || (mode == 1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #1 start = 1'b0;
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ((cyc + 1) % 3 == 0);
        2:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = (cyc >= 20);
      endcase
      if (mode == 3 && cyc == 20) begin
        check("hold_addr", ram_addr, 16'd4);
        check("hold_pix", {pix_valid, pix_data, 8'(popped)}, {1'b1, mem[0], 8'd0});
      end
      if (mid_start && !mid_done && popped == 3) begin
        start    = 1'b1;
        mid_done = 1;
      end
      if (abort_at >= 0 && popped >= abort_at) begin
        rst = 1'b1;
        #1 check("abort_state", {pix_valid, busy, frame_done}, 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_done_cnt", done_cnt, 0);
        exp_q.delete();
        return;
      end
      if (done_cnt > 0) extra++;
      if (extra >= 3) begin
        finished = 1;
        break;
      end
    end
    check("frame_finished", finished, 1);
    check("done_count", done_cnt, 1);
    check("exp_left", exp_q.size(), 0);
    check("busy_after", busy, 0);
    check("addr_bound", oob, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1 check("reset_outputs",
             {ram_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, frame_done}, 32'd0);
    rst = 1'b0;

    run_frame(0, 0, -1);
    run_frame(1, 0, -1);
    run_frame(0, 1, -1);
    run_frame(0, 0, 6);
    run_frame(0, 0, -1);
    run_frame(3, 0, -1);
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
      run_frame(2, f[0], -1);
    end
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    run_frame(1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_scan_reader.md
Name: fb_scan_reader

Overview:
Read-side client of the framebuffer dual-port RAM. On a frame-start pulse it walks the RAM linearly from address 0 to H_ACTIVE*V_ACTIVE-1 through the read port. It absorbs the RAM's 1-cycle read latency in a small prefetch FIFO and presents a valid/ready pixel stream with line/frame markers to the HDMI pixel path.

Parameters:
DATA_WIDTH, 8, pixel/RAM word width
ADDR_WIDTH, 16, RAM address width; H_ACTIVE*V_ACTIVE <= 2**ADDR_WIDTH
H_ACTIVE, 160, pixels per line stored in RAM
V_ACTIVE, 120, lines per frame stored in RAM
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous active-high reset
start  in  1  1-cycle pulse, begin frame scan (ignored unless IDLE)
ram_addr  out  ADDR_WIDTH  RAM read address
ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_addr
pix_valid  out  1  pix_data holds a valid pixel
pix_ready  in  1  downstream accepts pixel when pix_valid&pix_ready
pix_data  out  DATA_WIDTH  pixel value
pix_sof  out  1  qualifies first pixel of frame
pix_eol  out  1  qualifies last pixel of each line
pix_eof  out  1  qualifies last pixel of frame
busy  out  1  high from accepted start until frame_done
frame_done  out  1  1-cycle pulse after last pixel handshake

Behaviour:
- Reset values: ram_addr=0, pix_valid=0, pix_data=0, pix_sof/eol/eof=0, busy=0, frame_done=0, FIFO empty, state IDLE.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: start=1 -> FETCH, busy=1, fetch address=0, output x/y counters=0.
  - FETCH: issue a read when (fifo_count + inflight) < FIFO_DEPTH. Issue means present ram_addr = fetch address and set inflight for the next cycle. On the next cycle push ram_rdata into the FIFO and increment the address.
  - FETCH, issuing address H_ACTIVE*V_ACTIVE-1 -> DRAIN.
  - DRAIN: no new reads. FIFO empty and inflight=0 after the last handshake -> IDLE, frame_done=1 for one cycle, busy=0.
- Read scheme: the RAM read port has no enable, so ram_addr holds its last value when not issuing and the returned data is discarded unless inflight. At most one read is in flight per cycle. Sustained throughput is 1 pixel/clk when pix_ready is held high.
- Output:
  - pix_valid = FIFO not empty; pix_data = FIFO head (show-ahead).
  - Pop only on pix_valid&pix_ready.
  - pix_data stays stable while pix_valid&!pix_ready.
- Markers: output counters ox (0..H_ACTIVE-1) and oy (0..V_ACTIVE-1) advance on each handshake.
  - pix_sof = (ox==0 && oy==0)&pix_valid.
  - pix_eol = (ox==H_ACTIVE-1)&pix_valid.
  - pix_eof = eol && oy==V_ACTIVE-1.
  - ox wraps to 0 at H_ACTIVE-1 and increments oy.
- Simultaneous FIFO push and pop: count unchanged, and the push is never blocked by the full check, because the issue condition already reserves space.
- start while busy: ignored, no restart.
- rst mid-frame: immediate return to the reset state; FIFO contents dropped.
- Address arithmetic: ADDR_WIDTH wide with no wrap past the last pixel; the compare against H_ACTIVE*V_ACTIVE-1 is a parameter constant.

Optional Feature:
Macro FB_SCAN_DOUBLE_EN: 2x2 pixel replication for the low-resolution Mandelbrot buffer.
- With the macro: each FIFO entry is presented twice (pop on the second handshake). Each RAM line is fetched twice: the fetch address rewinds to the line start after the first pass. Output counters then span 2*H_ACTIVE by 2*V_ACTIVE, and markers use the doubled extents.
- Without the macro: 1:1 scan as described above.

Decomposition:
- Package fb_pkg:
  - state enum (IDLE/FETCH/DRAIN);
  - derived constants FB_PIXELS=H_ACTIVE*V_ACTIVE, FB_LAST=FB_PIXELS-1, FIFO_AW=log2(FIFO_DEPTH).
- One natural sub-module: fb_prefetch_fifo, a synchronous show-ahead FIFO with count output, same clk/rst.

Test Plan:
1. H=4,V=2, RAM preloaded 0..7, pix_ready=1, start pulse -> pixels 0..7 on consecutive cycles. sof on 0, eol on 3 and 7, eof on 7. frame_done one cycle after pixel 7; busy low afterwards.
2. Same setup, pix_ready toggling 1,0,0,1,... -> pix_data stable while stalled, no pixel lost or duplicated, FIFO never exceeds 4, ram_addr never exceeds 7.
3. start pulsed again mid-frame at pixel 3 -> ignored, sequence continues 4..7, single frame_done.
4. rst asserted asynchronously after pixel 5 -> same cycle pix_valid=0, busy=0. Then start -> clean frame 0..7 with sof on 0.
5. pix_ready=0 for 20 cycles after start -> exactly 4 reads issued, pix_data=0 held. Release -> full 0..7 sequence.
6. With FB_SCAN_DOUBLE_EN, H=2,V=2, RAM={A,B,C,D} -> stream A,A,B,B,A,A,B,B,C,C,D,D,C,C,D,D. eol on every 4th pixel, eof on the last.
